// File: rtl/spm_pkg.sv
// Shared types and constants for the serial-parallel multiplier.
package spm_pkg;

    // Default operand width for spm_gen.
    localparam int SPM_WIDTH = 32;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } spm_state_t;

endpackage

// File: rtl/spm_addsub.sv
// Combinational add/subtract unit used for the partial-product accumulation.
module spm_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    // y = a - b when sub is set, a + b otherwise (modulo 2^W).
    always_comb begin
        y = sub ? (a - b) : (a + b);
    end

endmodule

// File: rtl/spm_gen.sv
// Serial-parallel multiplier: parallel MC, serial MP (LSB first), unsigned or
// two's-complement per operation, full 2*WIDTH-bit product.
//
// Handshake: start is sampled only in IDLE or DONE; when accepted, MC/MP/sgn
// are captured at that edge and busy rises. done pulses for one cycle with P
// valid, exactly WIDTH+1 cycles after the accepting edge's cycle. start held
// high during done begins the next operation at that edge. start in RUN is
// ignored.
module spm_gen
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   MC,
    input  logic [WIDTH-1:0]   MP,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P,
    output spm_state_t         dbg_state
);

    localparam int CNT_W = $clog2(WIDTH);

    spm_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mc_r;
    logic [WIDTH-1:0] mp_sh;
    logic             sgn_r;
    logic [WIDTH:0]   hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH:0]   mc_ext;
    logic [WIDTH:0]   pp;
    logic             last;
    logic             sub;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   next_hi;
    logic [WIDTH-1:0] next_lo;
    logic             accept;

    // One iteration of the shift-add datapath: select the partial product,
    // accumulate (subtract on the signed MSB), then shift {hi, lo} right.
    always_comb begin
        mc_ext  = {sgn_r & mc_r[WIDTH-1], mc_r};
        pp      = mp_sh[0] ? mc_ext : '0;
        last    = (cnt == CNT_W'(WIDTH - 1));
        sub     = sgn_r & last;
        next_hi = {sgn_r & sum[WIDTH], sum[WIDTH:1]};
        next_lo = {sum[0], lo[WIDTH-1:1]};
        accept  = start & ((state == IDLE) | (state == DONE));
    end

    spm_addsub #(.W(WIDTH + 1)) u_addsub (
        .a   (hi),
        .b   (pp),
        .sub (sub),
        .y   (sum)
    );

    // Controller, counter, operand/accumulator registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mc_r  <= '0;
            mp_sh <= '0;
            sgn_r <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mc_r  <= MC;
                        mp_sh <= MP;
                        sgn_r <= sgn;
                        hi    <= '0;
                        lo    <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi    <= next_hi;
                    lo    <= next_lo;
                    mp_sh <= mp_sh >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        P     <= {next_hi[WIDTH-1:0], next_lo};
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: doc/spm_gen.md
# spm_gen

Parametrised serial-parallel multiplier, the successor to the fixed 32×32 SPM datapath. It multiplies a parallel multiplicand `MC` by a multiplier `MP` consumed one bit per cycle, LSB first. It selects unsigned or two's-complement operation per operation and returns the full 2·WIDTH-bit product with a one-cycle `done` pulse. It sits behind a register-mapped or streaming front end that drives `start`, and supports back-to-back operations.

## Interface
- `WIDTH`, 32, operand width in bits; legal range 2..64.
- `CNT_W`, $clog2(WIDTH), bit-counter width; derived, not overridden.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when the block can accept.
- `sgn`  in  1  1 = signed (two's complement), 0 = unsigned; captured with `start`.
- `MC`  in  WIDTH  multiplicand; captured with `start`.
- `MP`  in  WIDTH  multiplier; captured with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `P` is valid in that cycle.
- `P`  out  2·WIDTH  product; holds its value until the next completion or reset.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE: `start` captures `MC`, `MP` and `sgn`, clears the accumulator and counter, and moves to RUN.
  - RUN: executes exactly WIDTH iterations. At counter == WIDTH−1 the FSM moves to DONE.
  - DONE: `done` = 1. If `start` = 1, the block captures a new operation and moves to RUN; otherwise it moves to IDLE.
- `start` is ignored in RUN. It is not queued and does not corrupt the operands in flight.
- Datapath per RUN iteration:
  - pp = `MP_sh[0]` ? `MC_ext` : 0.
  - `MC_ext` is the (WIDTH+1)-bit extension of `MC`: sign-extended if `sgn`, zero-extended otherwise.
  - Final iteration with `sgn` = 1: hi ← hi − pp (the MSB of `MP` carries weight −2^(WIDTH−1)). All other iterations: hi ← hi + pp.
  - Then {hi, lo} shifts right 1. The shift is arithmetic if `sgn`, logical otherwise.
  - `MP_sh` shifts right 1.
- hi is WIDTH+1 bits, lo is WIDTH bits. On completion, `P` ← {hi[WIDTH−1:0], lo}.
- Results are exact for all operand pairs in both modes; no overflow is possible.
- `P` is updated only on the transition into DONE.

## Timing
- Reset values: `busy` = 0, `done` = 0, `P` = 0, FSM = IDLE, counter = 0.
- Reset applied mid-operation aborts the operation: no `done` pulse and `P` = 0 on the next cycle.
- When `start` is sampled at edge k:
  - `busy` = 1 from k+1 through k+WIDTH.
  - `done` = 1 and `P` is valid in the cycle after edge k+WIDTH.
  - Latency is WIDTH+1 cycles from the `start` edge to the `done` cycle.
- Back-to-back: `start` held high during `done` begins the next operation at that edge. Throughput is one product every WIDTH+1 cycles. `busy` stays 0 during the `done` cycle.
- Changes to `MC`, `MP` or `sgn` after capture have no effect on the operation in flight.
- `rst` and `start` asserted at the same edge: `rst` wins.

## Structure
- Package `spm_pkg` holds:
  - the state typedef `spm_state_t` (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the default `WIDTH` constant.
- One sub-module, `spm_addsub`: a (WIDTH+1)-bit add/subtract unit with a `sub` control.
  - Combinational; instantiated once by `spm_gen`.
- The FSM, counter and shift registers live in the top.

## Test plan
- Unsigned, WIDTH = 32: `MC` = 3, `MP` = 2, `sgn` = 0 → `done` 33 cycles after the `start` edge, `P` = 6, `busy` high for exactly 32 cycles.
- Signed: `MC` = 0xFFFFFFFD (−3), `MP` = 5, `sgn` = 1 → `P` = 0xFFFFFFFFFFFFFFF1 (−15).
- Corners:
  - unsigned 0xFFFFFFFF × 0xFFFFFFFF → `P` = 0xFFFFFFFE00000001;
  - signed 0x80000000 × 0x80000000 → `P` = 0x4000000000000000;
  - signed 0x80000000 × 0xFFFFFFFF → `P` = 0x0000000080000000.
- Back-to-back:
  - `start` held high across `done`, first op 7 × 9 then 10 × 20 → two `done` pulses 33 cycles apart with `P` = 63 then 200;
  - a `start` issued mid-RUN is ignored.
- Reset mid-op: `rst` = 1 for one cycle at RUN iteration 10 → `busy` = 0, `P` = 0, no `done`; a following `start` with 4 × 5 gives `P` = 20.
- Parameter sweep:
  - WIDTH = 8, 1000 random ops in each mode checked against `$signed`/`$unsigned` golden products;
  - signed −128 × −128 → `P` = 16'h4000.
